// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified memory port arbiter.
// State encoding, wait-counter sizing and the DMA word stride.
package mem_port_arbiter_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int WAIT_W       = 4;
   localparam int MAX_WAIT_DEF = 4;
   localparam int WORD_STRIDE  = 4;

   // Saturating increment used by both starvation counters.
   function automatic logic [WAIT_W-1:0] sat_inc(
      input logic [WAIT_W-1:0] v,
      input logic [WAIT_W-1:0] lim
   );
      return (v >= lim) ? v : v + WAIT_W'(1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_burst_ctr.sv
// DMA burst address/remaining-length counters.
// Word-aligns the start address and flags the final beat.
module dma_burst_ctr
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW    = 32,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [AW-1:0]    adr_i,
   input  logic [LEN_W-1:0] len_i,
   output logic [AW-1:0]    addr_o,
   output logic [LEN_W-1:0] rem_o,
   output logic             last_o
);

   logic [AW-1:0]    addr_q, addr_d;
   logic [LEN_W-1:0] rem_q, rem_d;

   always_comb begin
      addr_d = addr_q;
      rem_d  = rem_q;
      if (load_i) begin
         addr_d = {adr_i[AW-1:2], 2'b00};
         rem_d  = len_i;
      end else if (step_i) begin
         addr_d = addr_q + AW'(WORD_STRIDE);
         rem_d  = rem_q - LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= '0;
         rem_q  <= '0;
      end else begin
         addr_q <= addr_d;
         rem_q  <= rem_d;
      end
   end

   assign addr_o = addr_q;
   assign rem_o  = rem_q;
   assign last_o = (rem_q == LEN_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the core and a DMA burst engine.
// Both sides get bounded waits; every grant completes in its own cycle.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int LEN_W    = 8,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [AW-1:0]    cpu_adr,
   input  logic [DW-1:0]    cpu_wd,
   output logic             cpu_gnt,
   output logic [DW-1:0]    cpu_rd,
   input  logic             dma_req,
   input  logic             dma_we,
   input  logic [AW-1:0]    dma_adr,
   input  logic [LEN_W-1:0] dma_len,
   input  logic [DW-1:0]    dma_wd,
   output logic             dma_beat,
   output logic [DW-1:0]    dma_rd,
   output logic             dma_done,
   output logic             dma_busy,
   output logic             mem_we,
   output logic [AW-1:0]    mem_adr,
   output logic [DW-1:0]    mem_wd,
   input  logic [DW-1:0]    mem_rd
);

   localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

   logic [1:0]        st_q, st_d;
   logic [WAIT_W-1:0] cpu_wait_q, cpu_wait_d;
   logic [WAIT_W-1:0] dma_wait_q, dma_wait_d;
   logic              we_q, we_d;

   logic [AW-1:0]     addr_cnt;
   logic [LEN_W-1:0]  rem_cnt;
   logic              last_beat;

   logic              gnt, beat, start, done, busy;
   logic              idle_cpu, idle_dma, cpu_force;

   dma_burst_ctr #(
      .AW    (AW),
      .LEN_W (LEN_W)
   ) u_ctr (
      .clk    (clk),
      .reset  (reset),
      .load_i (start),
      .step_i (beat),
      .adr_i  (dma_adr),
      .len_i  (dma_len),
      .addr_o (addr_cnt),
      .rem_o  (rem_cnt),
      .last_o (last_beat)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q       <= ST_IDLE;
         cpu_wait_q <= '0;
         dma_wait_q <= '0;
         we_q       <= 1'b0;
      end else begin
         st_q       <= st_d;
         cpu_wait_q <= cpu_wait_d;
         dma_wait_q <= dma_wait_d;
         we_q       <= we_d;
      end
   end

   assign idle_cpu  = cpu_req &
                      (~dma_req | (dma_wait_q < MAX_W));
   assign idle_dma  = dma_req &
                      (~cpu_req | (dma_wait_q == MAX_W));
   assign cpu_force = cpu_req & (cpu_wait_q == MAX_W);

   // Outputs are forced quiet while reset is held so an aborted
   // burst cannot issue one more write in the reset cycle.
   always_comb begin
      gnt   = 1'b0;
      beat  = 1'b0;
      start = 1'b0;
      done  = 1'b0;
      busy  = 1'b0;
      if (!reset) begin
         unique case (1'b1)
            (st_q == ST_IDLE): begin
               gnt   = idle_cpu;
               start = idle_dma;
            end
            (st_q == ST_BURST): begin
               busy = 1'b1;
               gnt  = cpu_force;
               beat = ~cpu_force;
            end
            (st_q == ST_DONE): begin
               busy = 1'b1;
               done = 1'b1;
               gnt  = cpu_req;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      st_d = st_q;
      unique case (1'b1)
         (st_q == ST_IDLE):
            if (start)
               st_d = (dma_len == '0) ? ST_DONE : ST_BURST;
         (st_q == ST_BURST):
            if (beat && last_beat)
               st_d = ST_DONE;
         (st_q == ST_DONE):
            st_d = ST_IDLE;
         default:
            st_d = ST_IDLE;
      endcase
   end

   always_comb begin
      dma_wait_d = dma_wait_q;
      if (start)
         dma_wait_d = '0;
      else if (st_q == ST_IDLE && dma_req && gnt)
         dma_wait_d = sat_inc(dma_wait_q, MAX_W);

      cpu_wait_d = '0;
      if (st_q == ST_BURST && !gnt && cpu_req)
         cpu_wait_d = sat_inc(cpu_wait_q, MAX_W);

      we_d = start ? dma_we : we_q;
   end

   assign mem_we  = beat ? we_q : (gnt & cpu_we);
   assign mem_adr = beat ? addr_cnt : cpu_adr;
   assign mem_wd  = beat ? dma_wd : cpu_wd;

   assign cpu_gnt  = gnt;
   assign dma_beat = beat;
   assign dma_done = done;
   assign dma_busy = busy;
   assign cpu_rd   = mem_rd;
   assign dma_rd   = mem_rd;

endmodule
